alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters, e.g. the main execute path (port 0) and an address/branch helper (port 1). Each request is one operand pair plus a 4-bit ALU control code. The block registers the ALU inputs, captures the ALU result and zero flag one cycle later, and returns them on the requester's response channel with a valid/ready handshake. One operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that shares one ALU between two requesters.
// One operation in flight: IDLE (arbitrate) -> EXEC (ALU evaluates) -> RESP (handshake).
module alu_arbiter #(
  parameter int unsigned DataW = 32,
  parameter int unsigned CtrlW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [DataW-1:0] req0_a_i,
  input  logic [DataW-1:0] req0_b_i,
  input  logic [CtrlW-1:0] req0_op_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [DataW-1:0] req1_a_i,
  input  logic [DataW-1:0] req1_b_i,
  input  logic [CtrlW-1:0] req1_op_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [DataW-1:0] rsp0_data_o,
  output logic             rsp0_zero_o,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [DataW-1:0] rsp1_data_o,
  output logic             rsp1_zero_o,
  output logic [DataW-1:0] alu_in_1_o,
  output logic [DataW-1:0] alu_in_2_o,
  output logic [CtrlW-1:0] alu_ctrl_o,
  input  logic [DataW-1:0] alu_out_i,
  input  logic             alu_zero_i
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [DataW-1:0] alu_a_q, alu_a_d;
  logic [DataW-1:0] alu_b_q, alu_b_d;
  logic [CtrlW-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DataW-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             grant0, grant1;

  // On a tie the port that did not win last time is served.
  assign grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
  assign grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    result_d     = result_q;
    zero_d       = zero_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        if (grant0) begin
          alu_a_d      = req0_a_i;
          alu_b_d      = req0_b_i;
          alu_ctrl_d   = req0_op_i;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = StExec;
        end else if (grant1) begin
          alu_a_d      = req1_a_i;
          alu_b_d      = req1_b_i;
          alu_ctrl_d   = req1_op_i;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = StExec;
        end
      end
      StExec: begin
        result_d = alu_out_i;
        zero_d   = alu_zero_i;
        state_d  = StResp;
      end
      StResp: begin
        rsp0_valid_o = ~owner_q;
        rsp1_valid_o = owner_q;
        if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_in_1_o  = alu_a_q;
  assign alu_in_2_o  = alu_b_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  // Both response ports present the shared result; only valid qualifies them.
  assign rsp0_data_o = result_q;
  assign rsp1_data_o = result_q;
  assign rsp0_zero_o = zero_q;
  assign rsp1_zero_o = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_in_1, alu_in_2, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
    .req0_b_i(req0_b), .req0_op_i(req0_op),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
    .req1_b_i(req1_b), .req1_op_i(req1_op),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(rsp0_data),
    .rsp0_zero_o(rsp0_zero),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(rsp1_data),
    .rsp1_zero_o(rsp1_zero),
    .alu_in_1_o(alu_in_1), .alu_in_2_o(alu_in_2), .alu_ctrl_o(alu_ctrl),
    .alu_out_i(alu_out), .alu_zero_i(alu_zero)
  );

  // Reference ALU: unsupported codes give 0 with zero flag clear.
  always_comb begin
    alu_out  = '0;
    alu_zero = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_in_1 & alu_in_2;
      4'b0001: alu_out = alu_in_1 | alu_in_2;
      4'b0010: alu_out = alu_in_1 + alu_in_2;
      4'b0110: begin
        alu_out  = alu_in_1 - alu_in_2;
        alu_zero = (alu_out == 32'd0);
      end
      default: alu_out = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (alu_in_1 !== 32'd0) begin n_err++; $display("FAIL rst_in1 got %0h want 0", alu_in_1); end
    n_vec++; if (alu_in_2 !== 32'd0) begin n_err++; $display("FAIL rst_in2 got %0h want 0", alu_in_2); end
    n_vec++; if (alu_ctrl !== 4'd0) begin n_err++; $display("FAIL rst_ctrl got %0h want 0", alu_ctrl); end
    n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rst_rspv got %b want 00", {rsp0_valid, rsp1_valid}); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_reqr got %b want 00", {req0_ready, req1_ready}); end
    n_vec++; if ({rsp0_data, rsp0_zero} !== 33'd0) begin n_err++; $display("FAIL rst_res got %0h want 0", {rsp0_data, rsp0_zero}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    drive0(1'b1, 32'd5, 32'd7, 4'b0010);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL add_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_exec_v got %b want 0", rsp0_valid); end
    n_vec++; if ({alu_in_1, alu_in_2, alu_ctrl} !== {32'd5, 32'd7, 4'b0010}) begin n_err++; $display("FAIL add_aluin got %0h/%0h/%0h want 5/7/2", alu_in_1, alu_in_2, alu_ctrl); end
    tick();
    n_vec++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL add_rspv got %b want 1", rsp0_valid); end
    n_vec++; if (rsp0_data !== 32'd12) begin n_err++; $display("FAIL add_data got %0d want 12", rsp0_data); end
    n_vec++; if (rsp0_zero !== 1'b0) begin n_err++; $display("FAIL add_zero got %b want 0", rsp0_zero); end
    n_vec++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp1v got %b want 0", rsp1_valid); end
    tick();
    n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_idle_v got %b want 0", rsp0_valid); end
    n_vec++; if (alu_in_1 !== 32'd5) begin n_err++; $display("FAIL add_hold got %0h want 5", alu_in_1); end
  endtask

  task automatic test_tie();
    do_reset();
    drive0(1'b1, 32'd3, 32'd4, 4'b0010);
    drive1(1'b1, 32'd10, 32'd4, 4'b0110);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie1_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL tie1_exec_r1 got %b want 0", req1_ready); end
    tick();
    n_vec++; if ({rsp0_valid, rsp0_data} !== {1'b1, 32'd7}) begin n_err++; $display("FAIL tie1_rsp0 got %b/%0d want 1/7", rsp0_valid, rsp0_data); end
    tick();
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL tie1_r1 got %b want 1", req1_ready); end
    tick();
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    n_vec++; if ({rsp1_valid, rsp0_valid, rsp1_data, rsp1_zero} !== {2'b10, 32'd6, 1'b0}) begin n_err++; $display("FAIL tie1_rsp1 got %b%b/%0d/%b want 10/6/0", rsp1_valid, rsp0_valid, rsp1_data, rsp1_zero); end
    tick();
    // Port 1 won last, so the next tie goes to port 0.
    drive0(1'b1, 32'd1, 32'd1, 4'b0010);
    drive1(1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie2_ready got %b want 10", {req0_ready, req1_ready}); end
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
    drive0(1'b1, 32'd1, 32'd1, 4'b0010);
    drive1(1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL tie3_ready got %b want 01", {req0_ready, req1_ready}); end
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    n_vec++; if ({rsp1_valid, rsp1_data} !== {1'b1, 32'd4}) begin n_err++; $display("FAIL tie3_rsp1 got %b/%0d want 1/4", rsp1_valid, rsp1_data); end
    tick();
  endtask

  task automatic test_zero_flag();
    drive1(1'b1, 32'd9, 32'd9, 4'b0110);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL sub_ready got %b want 1", req1_ready); end
    tick();
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    n_vec++; if ({rsp1_valid, rsp1_data, rsp1_zero} !== {1'b1, 32'd0, 1'b1}) begin n_err++; $display("FAIL sub_zero got %b/%0h/%b want 1/0/1", rsp1_valid, rsp1_data, rsp1_zero); end
    tick();
    drive0(1'b1, 32'hF0, 32'h0F, 4'b0000);
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    n_vec++; if ({rsp0_valid, rsp0_data, rsp0_zero} !== {1'b1, 32'd0, 1'b0}) begin n_err++; $display("FAIL and_zero got %b/%0h/%b want 1/0/0", rsp0_valid, rsp0_data, rsp0_zero); end
    tick();
  endtask

  task automatic test_stall();
    rsp0_ready = 1'b0;
    drive0(1'b1, 32'hA0, 32'h05, 4'b0001);
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    drive1(1'b1, 32'd1, 32'd2, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if ({rsp0_valid, rsp0_data, req1_ready} !== {1'b1, 32'hA5, 1'b0}) begin n_err++; $display("FAIL stall_%0d got %b/%0h/%b want 1/a5/0", i, rsp0_valid, rsp0_data, req1_ready); end
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL stall_rel_r1 got %b want 0", req1_ready); end
    tick();
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL stall_next_r1 got %b want 1", req1_ready); end
    tick();
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    n_vec++; if ({rsp1_valid, rsp1_data} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL stall_rsp1 got %b/%0d want 1/3", rsp1_valid, rsp1_data); end
    tick();
  endtask

  task automatic test_unsupported_op();
    drive0(1'b1, 32'd1, 32'd1, 4'b0111);
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    n_vec++; if ({rsp0_valid, alu_ctrl} !== {1'b0, 4'b0111}) begin n_err++; $display("FAIL unsup_exec got %b/%0h want 0/7", rsp0_valid, alu_ctrl); end
    tick();
    n_vec++; if ({rsp0_valid, rsp0_data, rsp0_zero} !== {1'b1, 32'd0, 1'b0}) begin n_err++; $display("FAIL unsup_rsp got %b/%0h/%b want 1/0/0", rsp0_valid, rsp0_data, rsp0_zero); end
    tick();
  endtask

  task automatic test_async_reset();
    drive0(1'b1, 32'd5, 32'd5, 4'b0010);
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({alu_in_1, alu_in_2, alu_ctrl} !== 68'd0) begin n_err++; $display("FAIL arst_alu got %0h/%0h/%0h want 0/0/0", alu_in_1, alu_in_2, alu_ctrl); end
    n_vec++; if ({rsp0_valid, rsp1_valid, rsp0_data} !== 34'd0) begin n_err++; $display("FAIL arst_rsp got %b%b/%0h want 00/0", rsp0_valid, rsp1_valid, rsp0_data); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL arst_norsp_%0d got %b want 00", i, {rsp0_valid, rsp1_valid}); end
    end
    drive0(1'b1, 32'd1, 32'd1, 4'b0010);
    drive1(1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL arst_tie got %b want 10", {req0_ready, req1_ready}); end
    tick();
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
  endtask

  initial begin
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive0(1'b0, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 32'd0, 32'd0, 4'd0);
    test_reset();
    test_single_add();
    test_tie();
    test_zero_flag();
    test_stall();
    test_unsupported_op();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
